// File: rtl/heart_rate_calc.sv
// Heart-rate calculator: peak detection with hysteresis and refractory window, BPM by restoring divide.
// Latency: peak 1 clk after the accepted sample; bpm_valid 17 clk after the peak pulse.
// Backpressure: none, i_sample_valid is always accepted; peaks arriving while busy drop their BPM.
//
// Ports:
//   i_clk, i_reset         clock, asynchronous active-high reset
//   i_sample[W-1:0]        filtered unsigned sample, qualified by i_sample_valid (1-cycle strobe)
//   o_peak                 1-cycle pulse after a peak is declared
//   o_bpm[7:0]             last heart rate (saturates at 255, 0 after signal loss)
//   o_bpm_valid            1-cycle pulse whenever o_bpm is updated
//   o_busy                 divider running
//   o_no_signal            no heartbeat currently tracked
module heart_rate_calc #(
  parameter int W              = 10,
  parameter int SAMPLE_RATE_HZ = 100,
  parameter int HYST           = 8,
  parameter int REFRACT        = 30,
  parameter int MAX_INTERVAL   = 300
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_sample,
  input  logic         i_sample_valid,
  output logic         o_peak,
  output logic [7:0]   o_bpm,
  output logic         o_bpm_valid,
  output logic         o_busy,
  output logic         o_no_signal
);

  localparam logic [15:0] MAX_I     = 16'(MAX_INTERVAL);
  localparam logic [15:0] REFRACT_I = 16'(REFRACT);
  localparam logic [15:0] DIVIDEND  = 16'(60 * SAMPLE_RATE_HZ);
  localparam logic [W:0]  HYST_W    = (W+1)'(HYST);

  typedef enum logic {ST_RISING = 1'b0, ST_FALLING = 1'b1} state_t;

  state_t       r_state, w_state_nxt;
  logic [W-1:0] r_ext, w_ext_nxt;
  logic [15:0]  r_cnt, w_cnt_n;
  logic         r_have_prev;
  logic         r_peak;
  logic         r_no_signal;

  logic [15:0]  r_div_rem, r_div_quo, r_div_dsr;
  logic [4:0]   r_div_step;
  logic         r_busy;
  logic [7:0]   r_bpm;
  logic         r_bpm_valid;
  logic         r_to_pend;

  // Comparisons are done one bit wider so sample+HYST / ext+HYST cannot wrap.
  logic [W:0]   w_s, w_e;
  logic         w_gt, w_lt, w_drop, w_rise, w_refr_ok;
  logic         w_peak_det, w_timeout, w_div_start;

  assign w_cnt_n   = (r_cnt >= MAX_I) ? MAX_I : r_cnt + 16'd1;
  assign w_s       = {1'b0, i_sample};
  assign w_e       = {1'b0, r_ext};
  assign w_gt      = w_s > w_e;
  assign w_lt      = w_s < w_e;
  assign w_drop    = (w_s + HYST_W) <= w_e;
  assign w_rise    = w_s >= (w_e + HYST_W);
  assign w_refr_ok = w_cnt_n >= REFRACT_I;

  // Peak FSM: state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_RISING;
      r_ext   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ext   <= w_ext_nxt;
    end
  end

  // Peak FSM: next state and tracked extreme
  always_comb begin
    w_state_nxt = r_state;
    w_ext_nxt   = r_ext;
    if (i_sample_valid) begin
      case (r_state)
        ST_RISING: begin
          if (w_gt) begin
            w_ext_nxt = i_sample;
          end else if (w_drop && w_refr_ok) begin
            w_state_nxt = ST_FALLING;
            w_ext_nxt   = i_sample;
          end
          // A drop inside the refractory window leaves state and ext untouched.
        end
        ST_FALLING: begin
          if (w_lt) begin
            w_ext_nxt = i_sample;
          end else if (w_rise) begin
            w_state_nxt = ST_RISING;
            w_ext_nxt   = i_sample;
          end
        end
        default: begin
          w_state_nxt = ST_RISING;
        end
      endcase
    end
  end

  // Peak FSM: outputs
  always_comb begin
    w_peak_det  = i_sample_valid && (r_state == ST_RISING) && !w_gt && w_drop && w_refr_ok;
    w_timeout   = i_sample_valid && r_have_prev && (w_cnt_n == MAX_I);
    // cnt_n < MAX also excludes the timeout sample, so a peak there never divides.
    w_div_start = w_peak_det && r_have_prev && (w_cnt_n < MAX_I) && !r_busy;
  end

  // Interval counter and tracking flags
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt       <= '0;
      r_have_prev <= 1'b0;
      r_no_signal <= 1'b1;
      r_peak      <= 1'b0;
    end else begin
      r_peak <= w_peak_det;
      if (i_sample_valid) begin
        r_cnt <= w_peak_det ? 16'd0 : w_cnt_n;
        if (w_timeout) begin
          r_have_prev <= 1'b0;
          r_no_signal <= 1'b1;
        end
        // A peak on the timeout sample restarts tracking as a first peak.
        if (w_peak_det) begin
          r_have_prev <= 1'b1;
          r_no_signal <= 1'b0;
        end
      end
    end
  end

  // Restoring divider step: shift in next dividend bit, subtract if it fits.
  logic [16:0] w_rem_sh;
  logic        w_ge;
  logic [15:0] w_diff, w_rem_nx, w_quo_nx;
  logic [7:0]  w_bpm_sat;

  assign w_rem_sh  = {r_div_rem, r_div_quo[15]};
  assign w_ge      = w_rem_sh >= {1'b0, r_div_dsr};
  assign w_diff    = w_rem_sh[15:0] - r_div_dsr;
  assign w_rem_nx  = w_ge ? w_diff : w_rem_sh[15:0];
  assign w_quo_nx  = {r_div_quo[14:0], w_ge};
  assign w_bpm_sat = (|r_div_quo[15:8]) ? 8'hFF : r_div_quo[7:0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div_rem   <= '0;
      r_div_quo   <= '0;
      r_div_dsr   <= '0;
      r_div_step  <= '0;
      r_busy      <= 1'b0;
      r_bpm       <= '0;
      r_bpm_valid <= 1'b0;
      r_to_pend   <= 1'b0;
    end else begin
      r_bpm_valid <= 1'b0;
      if (w_div_start) begin
        r_div_dsr  <= w_cnt_n;
        r_div_rem  <= '0;
        r_div_quo  <= DIVIDEND;
        r_div_step <= '0;
        r_busy     <= 1'b1;
      end else if (r_busy) begin
        if (r_div_step == 5'd16) begin
          r_bpm       <= w_bpm_sat;
          r_bpm_valid <= 1'b1;
          r_busy      <= 1'b0;
        end else begin
          r_div_rem  <= w_rem_nx;
          r_div_quo  <= w_quo_nx;
          r_div_step <= r_div_step + 5'd1;
        end
      end else if (r_to_pend) begin
        // Deferred signal-loss update, one cycle after the division result.
        r_bpm       <= '0;
        r_bpm_valid <= 1'b1;
        r_to_pend   <= 1'b0;
      end
      if (w_timeout) begin
        if (r_busy) begin
          r_to_pend <= 1'b1;
        end else begin
          r_bpm       <= '0;
          r_bpm_valid <= 1'b1;
        end
      end
    end
  end

  assign o_peak      = r_peak;
  assign o_bpm       = r_bpm;
  assign o_bpm_valid = r_bpm_valid;
  assign o_busy      = r_busy;
  assign o_no_signal = r_no_signal;

endmodule

// File: tb/tb_heart_rate_calc.sv
// Testbench for heart_rate_calc: directed beat waveforms with hand-computed BPM.
// Beats: ramp 0->200 over 'rise' samples, fall by 20/sample, then zeros; the peak is
// declared one sample after the apex, so the peak-to-peak interval equals the beat length.
module tb_heart_rate_calc;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sample;
  logic         sample_valid;

  logic         peak1, bv1, busy1, nos1;
  logic [7:0]   bpm1;
  logic         peak2, bv2, busy2, nos2;
  logic [7:0]   bpm2;

  always #5 clk = ~clk;

  heart_rate_calc #(.W(W), .SAMPLE_RATE_HZ(100), .HYST(8), .REFRACT(30), .MAX_INTERVAL(300)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_sample(sample), .i_sample_valid(sample_valid),
    .o_peak(peak1), .o_bpm(bpm1), .o_bpm_valid(bv1), .o_busy(busy1), .o_no_signal(nos1)
  );

  heart_rate_calc #(.W(W), .SAMPLE_RATE_HZ(100), .HYST(8), .REFRACT(10), .MAX_INTERVAL(300)) u_dut_r10 (
    .i_clk(clk), .i_reset(rst), .i_sample(sample), .i_sample_valid(sample_valid),
    .o_peak(peak2), .o_bpm(bpm2), .o_bpm_valid(bv2), .o_busy(busy2), .o_no_signal(nos2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pk_cnt[2] = '{0, 0};
  int bv_cnt[2] = '{0, 0};
  int pk_cyc[2] = '{0, 0};
  int bv_cyc[2] = '{0, 0};

  // Event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (peak1) begin pk_cnt[0]++; pk_cyc[0] = cyc; end
    if (bv1)   begin bv_cnt[0]++; bv_cyc[0] = cyc; end
    if (peak2) begin pk_cnt[1]++; pk_cyc[1] = cyc; end
    if (bv2)   begin bv_cnt[1]++; bv_cyc[1] = cyc; end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic emit(input int v);
    sample       = v[W-1:0];
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic int bval(input int rise, input int noisy, input int i);
    int v;
    if (i <= rise) begin
      v = i * 200 / rise;
      if (noisy != 0 && i >= 2 && i < rise) v = v + ((i % 2 == 0) ? 5 : -5);
    end else if (i < rise + 10) begin
      v = 200 - 20 * (i - rise);
    end else begin
      v = 0;
    end
    return v;
  endfunction

  task automatic beat(input int p, input int rise, input int noisy);
    for (int i = 0; i < p; i++) emit(bval(rise, noisy, i));
  endtask

  task automatic drain();
    repeat (25) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sample_valid = 1'b0;
    sample       = '0;
    rst          = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic lead();
    repeat (40) emit(0);
  endtask

  typedef struct {
    int lead;
    int dut;
    int period;
    int rise;
    int noisy;
    int exp_pk;
    int exp_bv;
    int exp_bpm;
    int exp_nosig;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int p0, b0;
    //            lead dut  P  rise noisy pk bv bpm nosig
    tbl[0]  = '{1, 0,  75, 10, 0, 1, 0,   0, 0};
    tbl[1]  = '{0, 0,  75, 10, 0, 1, 1,  80, 0};
    tbl[2]  = '{0, 0,  75, 10, 0, 1, 1,  80, 0};
    tbl[3]  = '{1, 0,  50, 10, 0, 1, 0,   0, 0};
    tbl[4]  = '{0, 0,  50, 10, 0, 1, 1, 120, 0};
    tbl[5]  = '{0, 0, 100, 10, 0, 1, 1, 120, 0};  // closes the last 50-sample interval
    tbl[6]  = '{0, 0, 100, 10, 0, 1, 1,  60, 0};
    tbl[7]  = '{1, 0,  75, 50, 1, 1, 0,   0, 0};
    tbl[8]  = '{0, 0,  75, 50, 1, 1, 1,  80, 0};
    tbl[9]  = '{0, 0,  75, 50, 1, 1, 1,  80, 0};
    tbl[10] = '{1, 1,  20, 10, 0, 1, 0,   0, 0};
    tbl[11] = '{0, 1,  20, 10, 0, 1, 1, 255, 0};
    tbl[12] = '{0, 1,  20, 10, 0, 1, 1, 255, 0};

    // Reset state
    rst = 1'b1;
    sample = '0;
    sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset peak", int'(peak1), 0);
    check("reset bpm", int'(bpm1), 0);
    check("reset bpm_valid", int'(bv1), 0);
    check("reset busy", int'(busy1), 0);
    check("reset no_signal", int'(nos1), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven beats
    for (int k = 0; k < 13; k++) begin
      vec_t v;
      int pa, ba, bpm_now, nos_now;
      v = tbl[k];
      if (v.lead != 0) begin
        do_reset();
        lead();
      end
      pa = pk_cnt[v.dut];
      ba = bv_cnt[v.dut];
      beat(v.period, v.rise, v.noisy);
      drain();
      bpm_now = (v.dut == 1) ? int'(bpm2) : int'(bpm1);
      nos_now = (v.dut == 1) ? int'(nos2) : int'(nos1);
      check($sformatf("vec%0d peaks", k), pk_cnt[v.dut] - pa, v.exp_pk);
      check($sformatf("vec%0d bpm_valid count", k), bv_cnt[v.dut] - ba, v.exp_bv);
      check($sformatf("vec%0d bpm", k), bpm_now, v.exp_bpm);
      check($sformatf("vec%0d no_signal", k), nos_now, v.exp_nosig);
      if (v.exp_bv == 1)
        check($sformatf("vec%0d latency", k), bv_cyc[v.dut] - pk_cyc[v.dut], 17);
    end

    // Refractory: a bump 20 samples after a peak is suppressed; next real peak 75 later.
    do_reset();
    lead();
    beat(75, 10, 0);
    beat(75, 10, 0);
    p0 = pk_cnt[0];
    b0 = bv_cnt[0];
    for (int i = 0; i <= 30; i++) emit(bval(10, 0, i));
    emit(20);
    emit(40);
    emit(32);
    repeat (41) emit(36);
    check("refract bump peaks", pk_cnt[0] - p0, 1);
    emit(36);
    emit(36);
    for (int j = 2; j < 75; j++) emit((j <= 10) ? 20 * j : bval(10, 0, j));
    drain();
    check("refract total peaks", pk_cnt[0] - p0, 2);
    check("refract bpm_valid count", bv_cnt[0] - b0, 2);
    check("refract bpm", int'(bpm1), 80);

    // Signal loss after 300 flat samples, then recovery.
    do_reset();
    lead();
    beat(75, 10, 0);
    beat(75, 10, 0);
    b0 = bv_cnt[0];
    repeat (236) emit(0);
    check("timeout early no_signal", int'(nos1), 0);
    check("timeout early bpm_valid", bv_cnt[0] - b0, 0);
    emit(0);
    repeat (3) @(posedge clk);
    #1;
    check("timeout no_signal", int'(nos1), 1);
    check("timeout bpm", int'(bpm1), 0);
    check("timeout bpm_valid count", bv_cnt[0] - b0, 1);
    repeat (100) emit(0);
    check("timeout no repeat", bv_cnt[0] - b0, 1);
    p0 = pk_cnt[0];
    beat(75, 10, 0);
    drain();
    check("recover first peak", pk_cnt[0] - p0, 1);
    check("recover no_signal", int'(nos1), 0);
    check("recover first no bpm", bv_cnt[0] - b0, 1);
    beat(75, 10, 0);
    drain();
    check("recover bpm_valid count", bv_cnt[0] - b0, 2);
    check("recover bpm", int'(bpm1), 80);

    // Reset five clocks into a division.
    do_reset();
    lead();
    beat(75, 10, 0);
    beat(75, 10, 0);
    check("pre-abort bpm", int'(bpm1), 80);
    b0 = bv_cnt[0];
    for (int i = 0; i <= 11; i++) emit(bval(10, 0, i));
    repeat (4) @(posedge clk);
    #1;
    check("abort busy before reset", int'(busy1), 1);
    rst = 1'b1;
    #1;
    check("abort peak", int'(peak1), 0);
    check("abort bpm", int'(bpm1), 0);
    check("abort bpm_valid", int'(bv1), 0);
    check("abort busy", int'(busy1), 0);
    check("abort no_signal", int'(nos1), 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("abort no bpm_valid", bv_cnt[0] - b0, 0);
    check("abort bpm after", int'(bpm1), 0);
    check("abort busy after", int'(busy1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
